// File: rtl/mic_sample_window.sv
// Per-channel circular window of SAMPLES words, presented as block or sliding frames with random-access read.
// Latency: frame_valid one cycle after the completing accept; rd_data one cycle after rd_ch/rd_idx.
// Backpressure: in_ready drops while a frame is held. Optional drop counter: MIC_SAMPLE_WINDOW_OVERRUN_EN.
module mic_sample_window #(
  parameter int SAMPLES  = 16,
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter int HOP      = 8,
  localparam int IDX_W   = $clog2(SAMPLES),
  localparam int CNT_W   = $clog2(SAMPLES + 1),
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      in_ready,
  input  logic                      mode,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  input  logic [CH_W-1:0]           rd_ch,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic [WIDTH-1:0]          rd_data,
`ifdef MIC_SAMPLE_WINDOW_OVERRUN_EN
  output logic [15:0]               overrun_cnt,
`endif
  output logic [CNT_W-1:0]          fill_count
);

  localparam logic [CNT_W-1:0] FULL   = CNT_W'(SAMPLES);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(SAMPLES - 1);
  localparam logic [CNT_W-1:0] KEEP   = CNT_W'(SAMPLES - HOP);
  localparam logic [IDX_W-1:0] HOP_M  = IDX_W'(HOP % SAMPLES);
  localparam logic [31:0]      CH_LIM = 32'(CHANNELS);

  logic [WIDTH-1:0] mem_q [CHANNELS][SAMPLES];

  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0] base_q, base_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             frame_valid_q, frame_valid_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             accept, release_frm, rd_ch_ok;
  logic [IDX_W-1:0] rd_addr;
  logic [CH_W-1:0]  rd_ch_safe;

  always_comb begin
    accept        = in_valid && !frame_valid_q;
    release_frm   = frame_valid_q && frame_ready;
    wr_ptr_d      = wr_ptr_q;
    base_d        = base_q;
    fill_d        = fill_q;
    frame_valid_d = frame_valid_q;
    mode_d        = mode_q;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + IDX_W'(1);
      if (fill_q != FULL) fill_d = fill_q + CNT_W'(1);
      if (fill_q == LAST) frame_valid_d = 1'b1;
    end

    // In sliding mode the newest SAMPLES-HOP words stay resident for the next frame.
    if (release_frm) begin
      frame_valid_d = 1'b0;
      if (mode_q) begin
        fill_d = KEEP;
        base_d = base_q + HOP_M;
      end else begin
        fill_d = '0;
        base_d = wr_ptr_q;
      end
    end

    if (fill_q == '0 && !frame_valid_q) mode_d = mode;

    rd_ch_ok   = 32'(rd_ch) < CH_LIM;
    rd_ch_safe = rd_ch_ok ? rd_ch : '0;
    rd_addr    = base_q + rd_idx;
    rd_data_d  = rd_ch_ok ? mem_q[rd_ch_safe][rd_addr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      base_q        <= '0;
      fill_q        <= '0;
      frame_valid_q <= 1'b0;
      mode_q        <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      base_q        <= base_d;
      fill_q        <= fill_d;
      frame_valid_q <= frame_valid_d;
      mode_q        <= mode_d;
      rd_data_q     <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        mem_q[c][wr_ptr_q] <= in_data[c*WIDTH +: WIDTH];
      end
    end
  end

`ifdef MIC_SAMPLE_WINDOW_OVERRUN_EN
  logic [15:0] overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (in_valid && frame_valid_q && overrun_q != 16'hFFFF) overrun_d = overrun_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_q <= '0;
    else        overrun_q <= overrun_d;
  end

  assign overrun_cnt = overrun_q;
`endif

  assign in_ready    = !frame_valid_q;
  assign frame_valid = frame_valid_q;
  assign fill_count  = fill_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_mic_sample_window.sv
// Directed bench for mic_sample_window with SAMPLES=4, HOP=2, CHANNELS=2, WIDTH=8.
module tb_mic_sample_window;
  localparam int S = 4;
  localparam int W = 8;
  localparam int C = 2;
  localparam int H = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [C*W-1:0] in_data;
  logic         in_ready;
  logic         mode;
  logic         frame_valid;
  logic         frame_ready;
  logic [0:0]   rd_ch;
  logic [1:0]   rd_idx;
  logic [W-1:0] rd_data;
  logic [2:0]   fill_count;
`ifdef MIC_SAMPLE_WINDOW_OVERRUN_EN
  logic [15:0]  overrun_cnt;
`endif

  int errors = 0;
  int checks = 0;

  mic_sample_window #(.SAMPLES(S), .WIDTH(W), .CHANNELS(C), .HOP(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mode(mode), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .rd_ch(rd_ch), .rd_idx(rd_idx), .rd_data(rd_data),
`ifdef MIC_SAMPLE_WINDOW_OVERRUN_EN
    .overrun_cnt(overrun_cnt),
`endif
    .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = {b, a};
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic rd(input int ch, input int idx, output logic [7:0] d);
    rd_ch  = ch[0:0];
    rd_idx = idx[1:0];
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic rel_frame();
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = 1'b0;
    frame_ready = 1'b0; rd_ch = '0; rd_idx = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (fill_count !== 3'd0) begin errors++; $display("FAIL reset_fill got=%0d exp=0", fill_count); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_block();
    logic [7:0] d;
    mode = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(8'(1 + i), 8'(8'h11 + i));
      if (i == 2) begin
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL blk_fv_early got=%b exp=0", frame_valid); end
      end
    end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL blk_fv got=%b exp=1", frame_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL blk_in_ready got=%b exp=0", in_ready); end
    checks++; if (fill_count !== 3'd4) begin errors++; $display("FAIL blk_fill got=%0d exp=4", fill_count); end
    rd(1, 0, d);
    checks++; if (d !== 8'h11) begin errors++; $display("FAIL blk_rd_c1_i0 got=%h exp=11", d); end
    rd(1, 3, d);
    checks++; if (d !== 8'h14) begin errors++; $display("FAIL blk_rd_c1_i3 got=%h exp=14", d); end
    rd(0, 2, d);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL blk_rd_c0_i2 got=%h exp=03", d); end
    rel_frame();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL blk_rel_fv got=%b exp=0", frame_valid); end
    checks++; if (fill_count !== 3'd0) begin errors++; $display("FAIL blk_rel_fill got=%0d exp=0", fill_count); end
  endtask

  task automatic test_sliding();
    logic [7:0] d;
    mode = 1'b1;
    do_reset();
    for (int v = 1; v <= 4; v++) push(8'(v), 8'(8'h20 + v));
    for (int k = 0; k < 4; k++) begin
      rd(0, k, d);
      checks++; if (d !== 8'(k + 1)) begin errors++; $display("FAIL sl_f0_idx%0d got=%h exp=%h", k, d, 8'(k + 1)); end
    end
    rel_frame();
    checks++; if (fill_count !== 3'd2) begin errors++; $display("FAIL sl_rel_fill got=%0d exp=2", fill_count); end
    push(8'd5, 8'h25);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL sl_fv_after5 got=%b exp=0", frame_valid); end
    push(8'd6, 8'h26);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL sl_fv_after6 got=%b exp=1", frame_valid); end
    for (int k = 0; k < 4; k++) begin
      rd(0, k, d);
      checks++; if (d !== 8'(k + 3)) begin errors++; $display("FAIL sl_f1_idx%0d got=%h exp=%h", k, d, 8'(k + 3)); end
    end
    rd(1, 3, d);
    checks++; if (d !== 8'h26) begin errors++; $display("FAIL sl_f1_c1_i3 got=%h exp=26", d); end
    rel_frame();
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    mode = 1'b1;
    do_reset();
    for (int v = 1; v <= 4; v++) push(8'(v), 8'h00);
    for (int f = 0; f < 4; f++) begin
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL wr_fv_f%0d got=%b exp=1", f, frame_valid); end
      for (int k = 0; k < 4; k++) begin
        rd(0, k, d);
        checks++;
        if (d !== 8'(2 * f + 1 + k)) begin
          errors++; $display("FAIL wr_f%0d_idx%0d got=%h exp=%h", f, k, d, 8'(2 * f + 1 + k));
        end
      end
      rel_frame();
      if (f < 3) begin
        push(8'(2 * f + 5), 8'h00);
        push(8'(2 * f + 6), 8'h00);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    mode = 1'b0;
    do_reset();
    for (int v = 1; v <= 4; v++) push(8'(v), 8'(8'h10 + v));
    in_valid = 1'b1; in_data = {8'h19, 8'h09}; frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL b2b_fv got=%b exp=0", frame_valid); end
    checks++; if (fill_count !== 3'd0) begin errors++; $display("FAIL b2b_fill0 got=%0d exp=0", fill_count); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (fill_count !== 3'd1) begin errors++; $display("FAIL b2b_fill1 got=%0d exp=1", fill_count); end
    push(8'd10, 8'h1a); push(8'd11, 8'h1b); push(8'd12, 8'h1c);
    rd(0, 0, d);
    checks++; if (d !== 8'h09) begin errors++; $display("FAIL b2b_rd_i0 got=%h exp=09", d); end
    rd(1, 3, d);
    checks++; if (d !== 8'h1c) begin errors++; $display("FAIL b2b_rd_c1_i3 got=%h exp=1c", d); end
    rel_frame();
  endtask

  task automatic test_reset_midfill();
    mode = 1'b0;
    do_reset();
    push(8'd1, 8'h0); push(8'd2, 8'h0); push(8'd3, 8'h0);
    checks++; if (fill_count !== 3'd3) begin errors++; $display("FAIL rm_fill3 got=%0d exp=3", fill_count); end
    rst_n = 1'b0;
    #1;
    checks++; if (fill_count !== 3'd0) begin errors++; $display("FAIL rm_async_fill got=%0d exp=0", fill_count); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rm_async_fv got=%b exp=0", frame_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    push(8'd4, 8'h0); push(8'd5, 8'h0); push(8'd6, 8'h0);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rm_fv_after3 got=%b exp=0", frame_valid); end
    push(8'd7, 8'h0);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL rm_fv_after4 got=%b exp=1", frame_valid); end
    rel_frame();
    // Mode toggled mid-fill must not take effect for the frame already in progress.
    push(8'd1, 8'h0); push(8'd2, 8'h0);
    mode = 1'b1;
    push(8'd3, 8'h0); push(8'd4, 8'h0);
    rel_frame();
    checks++; if (fill_count !== 3'd0) begin errors++; $display("FAIL ml_block_rel got=%0d exp=0", fill_count); end
    for (int v = 1; v <= 4; v++) push(8'(v), 8'h0);
    rel_frame();
    checks++; if (fill_count !== 3'd2) begin errors++; $display("FAIL ml_slide_rel got=%0d exp=2", fill_count); end
  endtask

`ifdef MIC_SAMPLE_WINDOW_OVERRUN_EN
  task automatic test_overrun();
    mode = 1'b0;
    do_reset();
    for (int v = 1; v <= 4; v++) push(8'(v), 8'h0);
    checks++; if (overrun_cnt !== 16'd0) begin errors++; $display("FAIL ov_start got=%0d exp=0", overrun_cnt); end
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    checks++; if (overrun_cnt !== 16'd5) begin errors++; $display("FAIL ov_cnt got=%0d exp=5", overrun_cnt); end
    do_reset();
    checks++; if (overrun_cnt !== 16'd0) begin errors++; $display("FAIL ov_reset got=%0d exp=0", overrun_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_block();
    test_sliding();
    test_wrap();
    test_back_to_back();
    test_reset_midfill();
`ifdef MIC_SAMPLE_WINDOW_OVERRUN_EN
    test_overrun();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mic_sample_window.md
Name: mic_sample_window

Overview:
- Multi-channel sample window buffer between the microphone ADC sample stream and downstream frame processing (FFT/correlation).
- Collects SAMPLES words per channel into per-channel circular storage and presents completed frames.
- Two frame modes: block (non-overlapping) and sliding (overlapping by SAMPLES-HOP).
- Random-access read port for the frame, plus a valid/ready frame handshake.

Parameters:
- SAMPLES, 16: samples per channel per frame; power of two, >=2.
- WIDTH, 32: bits per sample.
- CHANNELS, 2: number of microphone channels, >=1.
- HOP, 8: new samples between frames in sliding mode; 1<=HOP<=SAMPLES. Ignored in block mode.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data holds one sample for every channel.
- in_data  in  CHANNELS*WIDTH  channel c is bits [c*WIDTH +: WIDTH].
- in_ready  out  1  block can accept a sample set.
- mode  in  1  0 = block, 1 = sliding.
- frame_valid  out  1  complete frame held and readable.
- frame_ready  in  1  consumer releases the frame.
- rd_ch  in  $clog2(CHANNELS) (min 1)  read channel select.
- rd_idx  in  $clog2(SAMPLES)  read index; 0 = oldest sample in the frame.
- rd_data  out  WIDTH  registered read data.
- fill_count  out  $clog2(SAMPLES+1)  samples currently held per channel.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr=0, base=0, fill_count=0.
  - frame_valid=0, rd_data=0, mode_q=0.
  - Storage contents are don't-care after reset.
  - Reset mid-fill or mid-frame discards everything.
- in_ready = !frame_valid (combinational). No sample is accepted while a frame is held.
- Accept: occurs when in_valid && in_ready on a clock edge.
  - Each channel's sample is written at wr_ptr.
  - wr_ptr wraps modulo SAMPLES.
  - fill_count increments by 1, saturating at SAMPLES.
- Frame complete: frame_valid is set on the same edge that accepts the sample making fill_count==SAMPLES. It is visible in the next cycle (latency 1 from the last accept).
- Release: occurs when frame_valid && frame_ready on a clock edge.
  - frame_valid clears.
  - Block mode: fill_count becomes 0; base advances by SAMPLES (i.e. unchanged modulo SAMPLES); base equals wr_ptr.
  - Sliding mode: fill_count becomes SAMPLES-HOP; base advances by HOP modulo SAMPLES.
  - With HOP=SAMPLES, sliding mode behaves exactly like block mode.
- frame_ready while frame_valid is low is ignored.
- Simultaneous release and in_valid: the sample is not accepted that cycle, because in_ready is low. It is accepted on a later cycle when in_ready is high.
- Mode latch: mode is latched into mode_q only on edges where fill_count==0 and frame_valid==0. Otherwise the change is ignored until that condition next holds. mode_q governs all behaviour.
- Read: rd_data <= mem[rd_ch][(base+rd_idx) mod SAMPLES] every cycle, regardless of frame_valid.
  - 1-cycle latency.
  - rd_ch >= CHANNELS returns 0.
  - Contents are stable only while frame_valid=1.
- fill_count reflects post-edge state; the consumer may use it for progress.

Optional Feature:
- Macro: MIC_SAMPLE_WINDOW_OVERRUN_EN.
- Defined:
  - Adds output port overrun_cnt, 16 bits.
  - Increments on each edge with in_valid && !in_ready, saturating at 0xFFFF.
  - Cleared only by reset.
  - Lets software detect ADC samples lost while a frame is held.
- Undefined: the port and counter are absent; dropped samples are not counted.

Test Plan:
All tests use SAMPLES=4, HOP=2, CHANNELS=2, WIDTH=8.
1. Block mode, push (ch0,ch1) = (1,0x11)..(4,0x14) on consecutive cycles -> frame_valid=1 the cycle after the 4th accept; in_ready=0; rd_ch=1, rd_idx=0 gives rd_data=0x11 one cycle later; rd_idx=3 gives 0x14.
2. Sliding mode, push ch0 = 1..6, pulse frame_ready after the first frame -> first frame is {1,2,3,4}; fill_count=2 after release; second frame_valid after 2 more accepts, reading {3,4,5,6}.
3. Sliding wrap-around, push 1..10, consuming each frame -> frames {1,2,3,4}, {3,4,5,6}, {5,6,7,8}, {7,8,9,10}; base wraps correctly.
4. Simultaneous: in_valid held high with frame_ready pulsed while frame_valid=1 (block mode) -> no accept that cycle; the next sample is written to index 0 of the new frame; fill_count goes 0 then 1.
5. Reset mid-fill: 3 samples accepted, then rst_n low for 1 cycle -> fill_count=0 and frame_valid=0 immediately; 4 fresh samples are needed for the next frame; mode toggled with fill_count=2 is not latched until fill_count=0.
6. With MIC_SAMPLE_WINDOW_OVERRUN_EN: hold in_valid=1 for 5 cycles while a frame is pending -> overrun_cnt=5; after reset it is 0.
